// File: rtl/perceptron_trainer.sv
// perceptron_trainer: argmax over latched class scores, then streams pixels and writes back perceptron weight updates.
// Define TRAIN_SATURATE_EN for saturating weight updates; otherwise updates wrap in two's complement.
module perceptron_trainer #(
  parameter int NUM_CLASSES = 10,
  parameter int WEIGHT_W = 16,
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W = 10,
  parameter int STEP = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [$clog2(NUM_CLASSES)-1:0] label,
  input  logic [NUM_CLASSES*WEIGHT_W-1:0] scores,
  input  logic pix_valid,
  input  logic pix_data,
  output logic pix_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [NUM_CLASSES*WEIGHT_W-1:0] weights_rd,
  output logic wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NUM_CLASSES*WEIGHT_W-1:0] weights_wr,
  output logic busy,
  output logic done,
  output logic [$clog2(NUM_CLASSES)-1:0] pred,
  output logic mispredict,
  output logic [15:0] err_count
);
  localparam int LW = $clog2(NUM_CLASSES);
  localparam int PW = $clog2(NUM_PIXELS + 1);
  typedef enum logic [1:0] {IDLE, ARGMAX, UPDATE, DONE} state_t;
  state_t state, state_n;
  logic [LW-1:0] lbl, cls_idx, best_idx, win;
  logic signed [WEIGHT_W-1:0] sc [NUM_CLASSES];
  logic signed [WEIGHT_W-1:0] best_val;
  logic [PW-1:0] pix_cnt;
  logic last_cls, take, hs;

  function automatic logic [WEIGHT_W-1:0] upd(input logic [WEIGHT_W-1:0] w, input logic inc, input logic dec);
`ifdef TRAIN_SATURATE_EN
    logic [WEIGHT_W:0] s;
    s = {w[WEIGHT_W-1], w} + (inc ? (WEIGHT_W+1)'(STEP) : '0) - (dec ? (WEIGHT_W+1)'(STEP) : '0);
    return (s[WEIGHT_W] != s[WEIGHT_W-1]) ? {s[WEIGHT_W], {(WEIGHT_W-1){~s[WEIGHT_W]}}} : s[WEIGHT_W-1:0];
`else
    return w + (inc ? WEIGHT_W'(STEP) : '0) - (dec ? WEIGHT_W'(STEP) : '0);
`endif
  endfunction

  assign last_cls = cls_idx == LW'(NUM_CLASSES - 1);
  assign take = cls_idx == '0 || sc[cls_idx] > best_val;
  assign win = take ? cls_idx : best_idx;
  assign pix_ready = state == UPDATE && pix_cnt != PW'(NUM_PIXELS);
  assign hs = pix_valid && pix_ready;
  assign rd_addr = state == UPDATE ? ADDR_W'(pix_cnt) : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;

  always_comb begin
    state_n = state == IDLE   ? (start ? ARGMAX : IDLE) :
              state == ARGMAX ? (last_cls ? UPDATE : ARGMAX) :
              state == UPDATE ? (pix_cnt == PW'(NUM_PIXELS) ? DONE : UPDATE) : IDLE;
  end

  // write data is only meaningful while wr_en is high; zero otherwise keeps outputs quiet in reset
  always_comb begin
    weights_wr = '0;
    for (int c = 0; c < NUM_CLASSES; c++)
      weights_wr[c*WEIGHT_W +: WEIGHT_W] = wr_en ? upd(weights_rd[c*WEIGHT_W +: WEIGHT_W], LW'(c) == lbl, LW'(c) == pred) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lbl <= '0;
      cls_idx <= '0;
      best_idx <= '0;
      best_val <= '0;
      pix_cnt <= '0;
      pred <= '0;
      mispredict <= 1'b0;
      err_count <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) sc[c] <= '0;
    end else begin
      state <= state_n;
      wr_en <= hs && mispredict && pix_data;
      if (hs) begin
        wr_addr <= ADDR_W'(pix_cnt);
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (state == IDLE && start) begin
        lbl <= label;
        cls_idx <= '0;
        pix_cnt <= '0;
        for (int c = 0; c < NUM_CLASSES; c++) sc[c] <= scores[c*WEIGHT_W +: WEIGHT_W];
      end
      if (state == ARGMAX) begin
        if (take) best_val <= sc[cls_idx];
        best_idx <= win;
        cls_idx <= cls_idx + 1'b1;
        if (last_cls) begin
          pred <= win;
          mispredict <= win != lbl;
        end
      end
      if (state == DONE && mispredict && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
    end
  end
endmodule
